vending_timeout_timer: RTL and testbench

//  Seconds countdown timer fed by the 1 Hz output of frequencyDivider (sec_in), clocked by the 27 MHz board clock.

---
 rtl/vending_timeout_timer_pkg.sv | 19 +
 rtl/vending_timeout_timer_bin2bcd.sv | 34 +++
 rtl/vending_timeout_timer.sv | 151 +++++++++++++++
 tb/tb_vending_timeout_timer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_timeout_timer_pkg.sv
// Shared definitions for the vending-machine timeout timer.
// Holds the FSM state encoding and the default width/saturation values
// so the top level and any helper blocks agree on them.
// Optional feature macro used elsewhere in this slice: TIMER_BCD_EN.
package vending_timeout_timer_pkg;

    // Timer states; encodings are fixed so debug probes read the same everywhere
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timerState_t;

    // Default counter width in bits and the largest timeout in seconds
    localparam int DEFAULT_W       = 8;
    localparam int DEFAULT_MAX_SEC = 99;

endpackage

// File: rtl/vending_timeout_timer_bin2bcd.sv
// Binary to two-digit BCD converter for the seven-segment remaining-time display.
// Only present when TIMER_BCD_EN is defined; otherwise this file contributes nothing.
// Input is expected in 0..99; digits are saturated at 9 so a stray value cannot
// produce a non-decimal nibble on the display.
`ifdef TIMER_BCD_EN
module vending_timeout_timer_bin2bcd #(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [W-1:0] i_bin,
    output logic [3:0]   o_tens,
    output logic [3:0]   o_ones
);

    logic [W-1:0] w_tens;
    logic [W-1:0] w_ones;

    assign w_tens = i_bin / W'(10);
    assign w_ones = i_bin % W'(10);

    // Register the split digits so the display sees a clean value one cycle after the count
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_tens <= 4'd0;
            o_ones <= 4'd0;
        end else begin
            o_tens <= (w_tens > W'(9)) ? 4'd9 : w_tens[3:0];
            o_ones <= (w_ones > W'(9)) ? 4'd9 : w_ones[3:0];
        end
    end

endmodule
`endif

// File: rtl/vending_timeout_timer.sv
// Seconds countdown timer for the vending-machine controller.
// Counts falling edges of the 1 Hz sec_in strobe, runs at the 27 MHz board clock,
// and reports expiry to the vending FSM with a single-cycle pulse plus a sticky flag.
// Define TIMER_BCD_EN to add registered BCD digit outputs for the seven-segment display.
module vending_timeout_timer
    import vending_timeout_timer_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int MAX_SEC = DEFAULT_MAX_SEC
) (
    input  logic         freq_in,
    input  logic         reset,
    input  logic         sec_in,
    input  logic         start,
    input  logic [W-1:0] load_val,
    input  logic         kick,
    input  logic         pause,
    input  logic         cancel,
    output logic [W-1:0] remaining,
    output logic         running,
    output logic         expired,
    output logic         timeout_flag
`ifdef TIMER_BCD_EN
    ,
    output logic [3:0]   bcd_tens,
    output logic [3:0]   bcd_ones
`endif
);

    localparam logic [W-1:0] MAX_VAL = W'(MAX_SEC);

    timerState_t  r_state;
    timerState_t  w_nextState;
    logic [W-1:0] r_remaining;
    logic [W-1:0] w_nextRemaining;
    logic [W-1:0] r_reload;
    logic [W-1:0] w_nextReload;
    logic [W-1:0] w_loadClamped;
    logic         r_secPrev;
    logic         r_expired;
    logic         w_nextExpired;
    logic         r_running;
    logic         r_timeoutFlag;
    logic         w_tick;

    // sec_in idles high and drops for one cycle each second, so a falling edge marks a tick
    assign w_tick = r_secPrev & ~sec_in;

    // Full-width compare so large load values saturate instead of wrapping
    assign w_loadClamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Next-state logic; controls are resolved cancel, start, kick, pause, tick in that order,
    // and any tick that coincides with a higher-priority control is simply dropped
    always_comb begin
        w_nextState     = r_state;
        w_nextRemaining = r_remaining;
        w_nextReload    = r_reload;
        w_nextExpired   = 1'b0;

        if (cancel) begin
            w_nextState     = ST_IDLE;
            w_nextRemaining = '0;
        end else if (start) begin
            w_nextReload = w_loadClamped;
            if (w_loadClamped == '0) begin
                w_nextState     = ST_EXPIRED;
                w_nextRemaining = '0;
                w_nextExpired   = 1'b1;
            end else begin
                w_nextState     = ST_RUN;
                w_nextRemaining = w_loadClamped;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (kick) begin
                        w_nextRemaining = r_reload;
                    end else if (pause) begin
                        w_nextState = ST_PAUSE;
                    end else if (w_tick) begin
                        if (r_remaining <= W'(1)) begin
                            w_nextRemaining = '0;
                            w_nextState     = ST_EXPIRED;
                            w_nextExpired   = 1'b1;
                        end else begin
                            w_nextRemaining = r_remaining - W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (kick) begin
                        w_nextRemaining = r_reload;
                        w_nextState     = ST_RUN;
                    end else if (!pause) begin
                        w_nextState = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    w_nextRemaining = '0;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; status outputs are decoded from the next state so they
    // change on the same edge as remaining rather than a cycle later
    always_ff @(posedge freq_in) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_reload      <= '0;
            r_secPrev     <= 1'b1;
            r_expired     <= 1'b0;
            r_running     <= 1'b0;
            r_timeoutFlag <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_remaining   <= w_nextRemaining;
            r_reload      <= w_nextReload;
            r_secPrev     <= sec_in;
            r_expired     <= w_nextExpired;
            r_running     <= (w_nextState == ST_RUN) || (w_nextState == ST_PAUSE);
            r_timeoutFlag <= (w_nextState == ST_EXPIRED);
        end
    end

    assign remaining    = r_remaining;
    assign running      = r_running;
    assign expired      = r_expired;
    assign timeout_flag = r_timeoutFlag;

`ifdef TIMER_BCD_EN
    if (MAX_SEC > 99) begin : g_badMaxSec
        $error("vending_timeout_timer: MAX_SEC must be <= 99 when the BCD display output is enabled");
    end

    vending_timeout_timer_bin2bcd #(
        .W (W)
    ) u_bin2bcd (
        .i_clock (freq_in),
        .i_reset (reset),
        .i_bin   (r_remaining),
        .o_tens  (bcd_tens),
        .o_ones  (bcd_ones)
    );
`endif

endmodule

// File: tb/tb_vending_timeout_timer.sv
// Self-checking bench for vending_timeout_timer.
// A behavioural model of the timeout rules runs alongside the DUT and is compared every cycle;
// directed scenarios with hand-computed literal values pin the model, then a randomized run follows.
// With TIMER_BCD_EN defined the BCD digit outputs are connected and checked as well.
module tb_vending_timeout_timer;

    logic       freq_in = 1'b0;
    logic       reset   = 1'b1;
    logic       sec_in  = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       kick    = 1'b0;
    logic       pause   = 1'b0;
    logic       cancel  = 1'b0;
    logic [7:0] remaining;
    logic       running;
    logic       expired;
    logic       timeout_flag;
`ifdef TIMER_BCD_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
`endif

    int checks   = 0;
    int failures = 0;

    // Model of the timer: plain counters and flags describing what the customer would see
    int mRem      = 0;
    int mReload   = 0;
    bit mActive   = 0;
    bit mPaused   = 0;
    bit mTimedOut = 0;
    bit mPulse    = 0;
    bit mSecPrev  = 1;
    int mBcdSrc   = 0;
    bit mBcdReset = 1;

    vending_timeout_timer dut (
        .freq_in      (freq_in),
        .reset        (reset),
        .sec_in       (sec_in),
        .start        (start),
        .load_val     (load_val),
        .kick         (kick),
        .pause        (pause),
        .cancel       (cancel),
        .remaining    (remaining),
        .running      (running),
        .expired      (expired),
        .timeout_flag (timeout_flag)
`ifdef TIMER_BCD_EN
        ,
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
`endif
    );

    // 27 MHz board clock stand-in
    always #5 freq_in = ~freq_in;

    // Count one comparison and report it if the DUT value differs from the expectation
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs from a falling edge and return on the next falling edge
    task automatic applyStimulus(input bit st, input int lv, input bit kk, input bit ps,
                                 input bit cn, input bit secLow, input bit rst);
        start    = st;
        load_val = 8'(lv);
        kick     = kk;
        pause    = ps;
        cancel   = cn;
        sec_in   = !secLow;
        reset    = rst;
        @(negedge freq_in);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic secondTick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
    endtask

    // Advance the model on each rising edge, then compare DUT outputs just after the edge
    always @(posedge freq_in) begin : modelAndCompare
        bit tick;
        int clamped;
        tick    = mSecPrev && !sec_in;
        mBcdSrc = mRem;
        mPulse  = 0;
        if (reset) begin
            mRem = 0; mReload = 0; mActive = 0; mPaused = 0; mTimedOut = 0;
            mSecPrev = 1;
            mBcdReset = 1;
        end else begin
            mBcdReset = 0;
            clamped = (load_val > 99) ? 99 : int'(load_val);
            if (cancel) begin
                mActive = 0; mPaused = 0; mTimedOut = 0; mRem = 0;
            end else if (start) begin
                mReload = clamped;
                mPaused = 0;
                if (clamped == 0) begin
                    mActive = 0; mTimedOut = 1; mPulse = 1; mRem = 0;
                end else begin
                    mActive = 1; mTimedOut = 0; mRem = clamped;
                end
            end else if (mActive && kick) begin
                mRem = mReload;
                mPaused = 0;
            end else if (mActive && !mPaused && pause) begin
                mPaused = 1;
            end else if (mActive && mPaused) begin
                if (!pause) mPaused = 0;
            end else if (mActive && tick) begin
                if (mRem == 1) begin
                    mRem = 0; mActive = 0; mTimedOut = 1; mPulse = 1;
                end else begin
                    mRem = mRem - 1;
                end
            end
            mSecPrev = sec_in;
        end
        #1;
        checkOutput("cyc.remaining", int'(remaining), mRem);
        checkOutput("cyc.running", int'(running), int'(mActive));
        checkOutput("cyc.expired", int'(expired), int'(mPulse));
        checkOutput("cyc.timeout_flag", int'(timeout_flag), int'(mTimedOut));
`ifdef TIMER_BCD_EN
        checkOutput("cyc.bcd_tens", int'(bcd_tens), mBcdReset ? 0 : mBcdSrc / 10);
        checkOutput("cyc.bcd_ones", int'(bcd_ones), mBcdReset ? 0 : mBcdSrc % 10);
`endif
    end

    // Directed scenarios with literal expectations, then a randomized soak
    initial begin
        bit pauseLevel;
        bit lastLow;
        int lv;

        @(negedge freq_in);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset.remaining", int'(remaining), 0);
        checkOutput("reset.running", int'(running), 0);
        checkOutput("reset.expired", int'(expired), 0);
        checkOutput("reset.timeout_flag", int'(timeout_flag), 0);

        // Load 3 and count it down with three one-second strobes
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        checkOutput("load3.remaining", int'(remaining), 3);
        checkOutput("load3.running", int'(running), 1);
        idleCycle();
        idleCycle();
        checkOutput("load3.noTick", int'(remaining), 3);
        secondTick();
        checkOutput("tick1.remaining", int'(remaining), 2);
        idleCycle();
        secondTick();
        checkOutput("tick2.remaining", int'(remaining), 1);
        idleCycle();
        secondTick();
        checkOutput("tick3.remaining", int'(remaining), 0);
        checkOutput("tick3.expired", int'(expired), 1);
        checkOutput("tick3.timeout_flag", int'(timeout_flag), 1);
        checkOutput("tick3.running", int'(running), 0);
        idleCycle();
        checkOutput("afterExpire.expired", int'(expired), 0);
        checkOutput("afterExpire.timeout_flag", int'(timeout_flag), 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("kickInExpired.remaining", int'(remaining), 0);
        checkOutput("kickInExpired.timeout_flag", int'(timeout_flag), 1);

        // Oversized load saturates; zero load expires immediately
        applyStimulus(1, 150, 0, 0, 0, 0, 0);
        checkOutput("clamp.remaining", int'(remaining), 99);
        checkOutput("clamp.timeout_flag", int'(timeout_flag), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("zeroLoad.expired", int'(expired), 1);
        checkOutput("zeroLoad.timeout_flag", int'(timeout_flag), 1);
        checkOutput("zeroLoad.remaining", int'(remaining), 0);
        idleCycle();
        checkOutput("zeroLoad.pulseOnce", int'(expired), 0);

        // Pause freezes the count across two strobes, resumes afterwards
        applyStimulus(1, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("pause.remaining", int'(remaining), 5);
        checkOutput("pause.running", int'(running), 1);
        idleCycle();
        secondTick();
        checkOutput("resume.remaining", int'(remaining), 4);

        // Kick on the same cycle as a strobe reloads and drops the strobe
        applyStimulus(1, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            idleCycle();
            secondTick();
        end
        checkOutput("preKick.remaining", int'(remaining), 2);
        idleCycle();
        applyStimulus(0, 0, 1, 0, 0, 1, 0);
        checkOutput("kickTick.remaining", int'(remaining), 10);

        // Cancel from RUN returns to idle silently
        applyStimulus(1, 7, 0, 0, 0, 0, 0);
        checkOutput("cancelPre.remaining", int'(remaining), 7);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("cancel.remaining", int'(remaining), 0);
        checkOutput("cancel.running", int'(running), 0);
        checkOutput("cancel.expired", int'(expired), 0);
        checkOutput("cancel.timeout_flag", int'(timeout_flag), 0);
        secondTick();
        checkOutput("cancel.staysIdle", int'(remaining), 0);

        // Reset in the middle of a count
        applyStimulus(1, 7, 0, 0, 0, 0, 0);
        secondTick();
        checkOutput("midReset.pre", int'(remaining), 6);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("midReset.remaining", int'(remaining), 0);
        checkOutput("midReset.running", int'(running), 0);
        checkOutput("midReset.expired", int'(expired), 0);

`ifdef TIMER_BCD_EN
        applyStimulus(1, 47, 0, 0, 0, 0, 0);
        idleCycle();
        checkOutput("bcd47.tens", int'(bcd_tens), 4);
        checkOutput("bcd47.ones", int'(bcd_ones), 7);
`endif

        // Randomized soak: short timeouts, frequent strobes, occasional controls
        pauseLevel = 0;
        lastLow    = 0;
        for (int i = 0; i < 4000; i++) begin
            bit st, kk, cn, rst, low;
            st  = ($urandom_range(0, 99) < 3);
            kk  = ($urandom_range(0, 99) < 3);
            cn  = ($urandom_range(0, 199) < 1);
            rst = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 3) pauseLevel = !pauseLevel;
            low = !lastLow && ($urandom_range(0, 3) == 0);
            lastLow = low;
            if ($urandom_range(0, 9) < 7) lv = $urandom_range(0, 6);
            else lv = $urandom_range(0, 255);
            applyStimulus(st, lv, kk, pauseLevel, cn, low, rst);
        end

        idleCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
